// File: rtl/tcp_tx_framer_pkg.sv
// Shared types, widths and the payload pattern helper for the TCP TX framer.
package tcp_tx_framer_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SEQ_W  = 16;
    localparam int unsigned SW_W   = 4;

    localparam logic [BYTE_W-1:0] HDR0_DEF = 8'hA5;
    localparam logic [BYTE_W-1:0] HDR1_DEF = 8'h5A;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_H0,
        ST_H1,
        ST_SQH,
        ST_SQL,
        ST_LEN,
        ST_PAY,
        ST_CSUM,
        ST_GAP
    } state_t;

    // Payload byte idx: counter offset by SEQ low byte, or switch nibble over index nibble
    function automatic logic [BYTE_W-1:0] payload_byte(
        input logic              mode,
        input logic [SW_W-1:0]   sw,
        input logic [BYTE_W-1:0] idx,
        input logic [BYTE_W-1:0] seq_lo
    );
        return mode ? {sw, idx[3:0]} : BYTE_W'(idx + seq_lo);
    endfunction

endpackage

// File: rtl/tcp_tx_framer_if.sv
// Byte-write channel into the SiTCP TCP TX FIFO plus its connection/backpressure status.
interface tcp_tx_framer_if;
    import tcp_tx_framer_pkg::*;

    logic              TCP_OPEN_ACK;
    logic              TCP_TX_FULL;
    logic              TCP_TX_WR;
    logic [BYTE_W-1:0] TCP_TX_DATA;

    modport master (
        input  TCP_OPEN_ACK,
        input  TCP_TX_FULL,
        output TCP_TX_WR,
        output TCP_TX_DATA
    );

    modport slave (
        output TCP_OPEN_ACK,
        output TCP_TX_FULL,
        input  TCP_TX_WR,
        input  TCP_TX_DATA
    );
endinterface

// File: rtl/tcp_tx_framer.sv
// Framed packet generator into SiTCP TX: A5 5A | SEQ | LEN | payload | CSUM,
// with per-byte stall on TX_FULL and abort on connection loss.
module tcp_tx_framer
    import tcp_tx_framer_pkg::*;
#(
    parameter logic [BYTE_W-1:0] PAYLOAD_LEN = 8'd16,
    parameter logic [BYTE_W-1:0] HDR0        = HDR0_DEF,
    parameter logic [BYTE_W-1:0] HDR1        = HDR1_DEF,
    parameter logic [BYTE_W-1:0] GAP_CYCLES  = 8'd4
) (
    input  logic                 CLK_200M,
    input  logic                 SYS_RSTn,
    tcp_tx_framer_if.master      tx,
    input  logic                 START,
    input  logic                 CONT,
    input  logic                 MODE,
    input  logic [SW_W-1:0]      SW,
    output logic                 BUSY,
    output logic                 PKT_DONE,
    output logic [SEQ_W-1:0]     PKT_CNT
);

    state_t              state_q, state_d;
    logic [BYTE_W-1:0]   idx_q, idx_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic [BYTE_W-1:0]   csum_q, csum_d;
    logic [SEQ_W-1:0]    cnt_q, cnt_d;
    logic [BYTE_W-1:0]   gap_q, gap_d;
    logic [SW_W-1:0]     sw_q, sw_d;
    logic                mode_q, mode_d;
    logic                wr_q, wr_d;
    logic [BYTE_W-1:0]   data_q, data_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic [BYTE_W-1:0]   tx_byte;

    // Byte belonging to the current frame state
    always_comb begin
        tx_byte = 8'h00;
        case (state_q)
            ST_H0:   tx_byte = HDR0;
            ST_H1:   tx_byte = HDR1;
            ST_SQH:  tx_byte = seq_q[15:8];
            ST_SQL:  tx_byte = seq_q[7:0];
            ST_LEN:  tx_byte = PAYLOAD_LEN;
            ST_PAY:  tx_byte = payload_byte(mode_q, sw_q, idx_q, seq_q[7:0]);
            ST_CSUM: tx_byte = csum_q;
            default: tx_byte = 8'h00;
        endcase
    end

    // Next-state, byte issue, checksum and counters
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        csum_d  = csum_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        sw_d    = sw_q;
        mode_d  = mode_q;
        wr_d    = 1'b0;
        data_d  = data_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((START | CONT) & tx.TCP_OPEN_ACK) begin
                    state_d = ST_H0;
                    sw_d    = SW;
                    mode_d  = MODE;
                end
            end
            ST_GAP: begin
                if (gap_q == 8'd0) begin
                    if (CONT & tx.TCP_OPEN_ACK) begin
                        state_d = ST_H0;
                        sw_d    = SW;
                        mode_d  = MODE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = BYTE_W'(gap_q - 8'd1);
                end
            end
            default: begin
                if (!tx.TCP_OPEN_ACK) begin
                    // Connection lost: drop the partial frame and restart numbering
                    state_d = ST_IDLE;
                    seq_d   = '0;
                    idx_d   = '0;
                end else if (!tx.TCP_TX_FULL) begin
                    wr_d   = 1'b1;
                    data_d = tx_byte;
                    case (state_q)
                        ST_H0: begin
                            csum_d  = '0;
                            state_d = ST_H1;
                        end
                        ST_H1:  state_d = ST_SQH;
                        ST_SQH: begin
                            csum_d  = BYTE_W'(csum_q + tx_byte);
                            state_d = ST_SQL;
                        end
                        ST_SQL: begin
                            csum_d  = BYTE_W'(csum_q + tx_byte);
                            state_d = ST_LEN;
                        end
                        ST_LEN: begin
                            csum_d  = BYTE_W'(csum_q + tx_byte);
                            idx_d   = '0;
                            state_d = ST_PAY;
                        end
                        ST_PAY: begin
                            csum_d = BYTE_W'(csum_q + tx_byte);
                            idx_d  = BYTE_W'(idx_q + 8'd1);
                            if (idx_q == BYTE_W'(PAYLOAD_LEN - 8'd1)) begin
                                state_d = ST_CSUM;
                            end
                        end
                        ST_CSUM: begin
                            done_d = 1'b1;
                            cnt_d  = SEQ_W'(cnt_q + 16'd1);
                            seq_d  = SEQ_W'(seq_q + 16'd1);
                            if (!CONT) begin
                                state_d = ST_IDLE;
                            end else if (GAP_CYCLES == 8'd0) begin
                                state_d = ST_H0;
                                sw_d    = SW;
                                mode_d  = MODE;
                            end else begin
                                state_d = ST_GAP;
                                gap_d   = BYTE_W'(GAP_CYCLES - 8'd1);
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
        endcase

        busy_d = (state_d != ST_IDLE) && (state_d != ST_GAP);
    end

    always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            seq_q   <= '0;
            csum_q  <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            sw_q    <= '0;
            mode_q  <= 1'b0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            csum_q  <= csum_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            sw_q    <= sw_d;
            mode_q  <= mode_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign tx.TCP_TX_WR   = wr_q;
    assign tx.TCP_TX_DATA = data_q;
    assign BUSY           = busy_q;
    assign PKT_DONE       = done_q;
    assign PKT_CNT        = cnt_q;

endmodule

// File: tb/tb_tcp_tx_framer.sv
// Directed bench for tcp_tx_framer: frame contents, latency, stall, abort and continuous-mode gap.
module tb_tcp_tx_framer;
    import tcp_tx_framer_pkg::*;

    localparam logic [7:0] LEN = 8'd4;
    localparam logic [7:0] GAP = 8'd4;
    localparam int         FRM = 10;

    logic        CLK_200M = 1'b0;
    logic        SYS_RSTn = 1'b0;
    logic        START    = 1'b0;
    logic        CONT     = 1'b0;
    logic        MODE     = 1'b0;
    logic [3:0]  SW       = 4'h0;
    logic        BUSY;
    logic        PKT_DONE;
    logic [15:0] PKT_CNT;

    tcp_tx_framer_if bus();

    tcp_tx_framer #(
        .PAYLOAD_LEN (LEN),
        .HDR0        (8'hA5),
        .HDR1        (8'h5A),
        .GAP_CYCLES  (GAP)
    ) dut (
        .CLK_200M (CLK_200M),
        .SYS_RSTn (SYS_RSTn),
        .tx       (bus.master),
        .START    (START),
        .CONT     (CONT),
        .MODE     (MODE),
        .SW       (SW),
        .BUSY     (BUSY),
        .PKT_DONE (PKT_DONE),
        .PKT_CNT  (PKT_CNT)
    );

    always #5 CLK_200M = ~CLK_200M;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int stray    = 0;
    int st       = 0;

    logic [7:0] got[$];
    int         got_cyc[$];
    bit         got_done[$];

    always @(posedge CLK_200M) cyc <= cyc + 1;

    // Capture every written byte away from the active edge
    always @(negedge CLK_200M) begin
        if (bus.TCP_TX_WR) begin
            got.push_back(bus.TCP_TX_DATA);
            got_cyc.push_back(cyc);
            got_done.push_back(PKT_DONE);
        end else if (PKT_DONE) begin
            stray++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_cap();
        got.delete();
        got_cyc.delete();
        got_done.delete();
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        int k = 0;
        while (got.size() < n && k < budget) begin
            @(negedge CLK_200M);
            #1;
            k++;
        end
        chk({tag, " bytes_seen"}, 32'(got.size() >= n), 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge CLK_200M);
        START = 1'b1;
        st    = cyc;
        @(negedge CLK_200M);
        START = 1'b0;
    endtask

    function automatic logic [7:0] pay_byte(input int j, input logic [15:0] seq,
                                            input logic mode, input logic [3:0] sw);
        logic [7:0] i8;
        i8 = 8'(j);
        return mode ? {sw, i8[3:0]} : 8'(i8 + seq[7:0]);
    endfunction

    function automatic logic [7:0] model_byte(input int k, input logic [15:0] seq,
                                              input logic mode, input logic [3:0] sw);
        logic [7:0] sum;
        if (k == 0) return 8'hA5;
        if (k == 1) return 8'h5A;
        if (k == 2) return seq[15:8];
        if (k == 3) return seq[7:0];
        if (k == 4) return LEN;
        if (k < 5 + int'(LEN)) return pay_byte(k - 5, seq, mode, sw);
        sum = 8'(seq[15:8] + seq[7:0] + LEN);
        for (int j = 0; j < int'(LEN); j++) sum = 8'(sum + pay_byte(j, seq, mode, sw));
        return sum;
    endfunction

    task automatic check_vec(input string tag, input logic [7:0] v[FRM]);
        for (int k = 0; k < FRM; k++) begin
            chk($sformatf("%s byte%0d", tag, k), 32'(got[k]), 32'(v[k]));
            chk($sformatf("%s done%0d", tag, k), 32'(got_done[k]), 32'(k == FRM - 1));
        end
    endtask

    task automatic check_frame(input string tag, input int base, input logic [15:0] seq,
                               input logic mode, input logic [3:0] sw);
        for (int k = 0; k < FRM; k++) begin
            chk($sformatf("%s byte%0d", tag, k), 32'(got[base + k]), 32'(model_byte(k, seq, mode, sw)));
            chk($sformatf("%s done%0d", tag, k), 32'(got_done[base + k]), 32'(k == FRM - 1));
        end
    endtask

    logic [7:0] v1[FRM];
    logic [7:0] v2[FRM];
    logic [7:0] v3[FRM];

    initial begin
        int n0;
        int dsum;
        v1 = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h0A};
        v2 = '{8'hA5, 8'h5A, 8'h00, 8'h01, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0F};
        v3 = '{8'hA5, 8'h5A, 8'h00, 8'h02, 8'h04, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'h0C};
        bus.TCP_OPEN_ACK = 1'b0;
        bus.TCP_TX_FULL  = 1'b0;

        repeat (3) @(negedge CLK_200M);
        chk("rst wr",   32'(bus.TCP_TX_WR),   32'd0);
        chk("rst data", 32'(bus.TCP_TX_DATA), 32'd0);
        chk("rst busy", 32'(BUSY),            32'd0);
        chk("rst done", 32'(PKT_DONE),        32'd0);
        chk("rst cnt",  32'(PKT_CNT),         32'd0);
        SYS_RSTn = 1'b1;

        // No connection: START must not produce anything
        pulse_start();
        repeat (6) @(negedge CLK_200M);
        chk("noack idle", 32'(got.size()), 32'd0);
        bus.TCP_OPEN_ACK = 1'b1;

        // 1: first frame, counter pattern, SEQ 0000
        clear_cap();
        pulse_start();
        wait_bytes("t1", FRM, 60);
        chk("t1 latency", 32'(got_cyc[0] - st), 32'd2);
        check_vec("t1", v1);
        chk("t1 cnt", 32'(PKT_CNT), 32'd1);

        // 2: SEQ 0001; a second START mid-frame is dropped
        clear_cap();
        pulse_start();
        wait_bytes("t2a", 3, 20);
        pulse_start();
        wait_bytes("t2", FRM, 60);
        repeat (20) @(negedge CLK_200M);
        chk("t2 no_queue", 32'(got.size()), 32'(FRM));
        check_vec("t2", v2);
        chk("t2 cnt", 32'(PKT_CNT), 32'd2);

        // 3: switch pattern, SW/MODE latched at frame start
        clear_cap();
        MODE = 1'b1;
        SW   = 4'hC;
        pulse_start();
        MODE = 1'b0;
        SW   = 4'h3;
        wait_bytes("t3", FRM, 60);
        check_vec("t3", v3);
        chk("t3 cnt", 32'(PKT_CNT), 32'd3);

        // 4: backpressure for 10 cycles during payload
        clear_cap();
        pulse_start();
        wait_bytes("t4a", 7, 30);
        bus.TCP_TX_FULL = 1'b1;
        n0 = got.size();
        repeat (10) @(negedge CLK_200M);
        chk("t4 full_leak", 32'(got.size() - n0 <= 1), 32'd1);
        chk("t4 wr_stalled", 32'(bus.TCP_TX_WR), 32'd0);
        chk("t4 busy_stalled", 32'(BUSY), 32'd1);
        bus.TCP_TX_FULL = 1'b0;
        wait_bytes("t4", FRM, 60);
        check_frame("t4", 0, 16'h0003, 1'b0, 4'h0);
        chk("t4 cnt", 32'(PKT_CNT), 32'd4);

        // 5: connection drop mid-payload aborts and resets SEQ
        clear_cap();
        pulse_start();
        wait_bytes("t5a", 7, 30);
        bus.TCP_OPEN_ACK = 1'b0;
        @(negedge CLK_200M);
        #1;
        chk("t5 wr",   32'(bus.TCP_TX_WR), 32'd0);
        chk("t5 busy", 32'(BUSY),          32'd0);
        chk("t5 cnt",  32'(PKT_CNT),       32'd4);
        repeat (4) @(negedge CLK_200M);
        chk("t5 partial", 32'(got.size()), 32'd7);
        dsum = 0;
        foreach (got_done[i]) dsum += int'(got_done[i]);
        chk("t5 no_done", 32'(dsum), 32'd0);
        bus.TCP_OPEN_ACK = 1'b1;
        pulse_start();
        wait_bytes("t5", 7 + FRM, 60);
        check_frame("t5", 7, 16'h0000, 1'b0, 4'h0);
        chk("t5 cnt_after", 32'(PKT_CNT), 32'd5);

        // 6: continuous mode with a 4-cycle gap
        clear_cap();
        @(negedge CLK_200M);
        CONT = 1'b1;
        wait_bytes("t6", 2 * FRM, 100);
        CONT = 1'b0;
        check_frame("t6f0", 0, 16'h0001, 1'b0, 4'h0);
        check_frame("t6f1", FRM, 16'h0002, 1'b0, 4'h0);
        chk("t6 gap", 32'(got_cyc[FRM] - got_cyc[FRM - 1]), 32'(int'(GAP) + 1));
        repeat (20) @(negedge CLK_200M);
        chk("t6 stop", 32'(got.size()), 32'(2 * FRM));
        chk("t6 busy", 32'(BUSY), 32'd0);
        chk("t6 cnt", 32'(PKT_CNT), 32'd7);

        chk("stray done", 32'(stray), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
